// File: rtl/hsi_tx_coder.sv
// Manchester line coder for the slave transmit path: sync, 8 data bits (MSB first), odd parity,
// optional inter-message gap. All outputs are registered from next-state values.
//
// state | meaning
// IDLE  | line released, waiting for d_rdy or msg_end
// SYNC  | two-bit frame delimiter, half-bits H,H,L,L
// DATA  | eight Manchester data bits, MSB first
// PAR   | Manchester odd-parity bit
// GAP   | inter-message gap, line driven low
module hsi_tx_coder #(
   parameter int CLK_PER_HALFBIT = 4,
   parameter int GAP_BITS        = 3
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [7:0] d,
   input  logic       d_rdy,
   input  logic       msg_end,
   output logic       busy,
   output logic       tx,
   output logic       tx_en
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SYNC = 3'd1,
      DATA = 3'd2,
      PAR  = 3'd3,
      GAP  = 3'd4
   } state_t;

   localparam logic [7:0] HC_LAST  = 8'(CLK_PER_HALFBIT - 1);
   localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

   state_t     state, state_n;
   logic [7:0] hc, hc_n;
   logic       hb, hb_n;
   logic [3:0] bc, bc_n;
   logic [7:0] byte_q, byte_n;
   logic       gap_pend, gap_pend_n;
   logic       bit_end;
   logic       bit_v;
   logic       busy_n, tx_n;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= IDLE;
         hc       <= '0;
         hb       <= 1'b0;
         bc       <= '0;
         byte_q   <= '0;
         gap_pend <= 1'b0;
         busy     <= 1'b0;
         tx_en    <= 1'b0;
         tx       <= 1'b0;
      end else begin
         state    <= state_n;
         hc       <= hc_n;
         hb       <= hb_n;
         bc       <= bc_n;
         byte_q   <= byte_n;
         gap_pend <= gap_pend_n;
         busy     <= busy_n;
         tx_en    <= busy_n;
         tx       <= tx_n;
      end
   end

   assign bit_end = (hc == HC_LAST) && hb;

   always_comb begin
      state_n    = state;
      hc_n       = hc;
      hb_n       = hb;
      bc_n       = bc;
      byte_n     = byte_q;
      gap_pend_n = gap_pend;

      // Half-bit timing is shared by every non-idle state; wraps to hb=0 at each bit boundary.
      if (state != IDLE) begin
         if (hc == HC_LAST) begin
            hc_n = '0;
            hb_n = ~hb;
         end else begin
            hc_n = hc + 8'd1;
         end
      end

      case (state)
         IDLE: begin
            hc_n = '0;
            hb_n = 1'b0;
            bc_n = '0;
            if (d_rdy) begin
               byte_n     = d;
               gap_pend_n = msg_end;
               state_n    = SYNC;
            end else if (msg_end) begin
               state_n = GAP;
            end
         end
         SYNC: begin
            if (msg_end) gap_pend_n = 1'b1;
            if (bit_end) begin
               if (bc == 4'd1) begin
                  bc_n    = '0;
                  state_n = DATA;
               end else begin
                  bc_n = bc + 4'd1;
               end
            end
         end
         DATA: begin
            if (msg_end) gap_pend_n = 1'b1;
            if (bit_end) begin
               if (bc == 4'd7) begin
                  bc_n    = '0;
                  state_n = PAR;
               end else begin
                  bc_n = bc + 4'd1;
               end
            end
         end
         PAR: begin
            if (msg_end) gap_pend_n = 1'b1;
            // msg_end on the very last parity cycle still earns a gap.
            if (bit_end) begin
               bc_n = '0;
               if (gap_pend || msg_end) begin
                  gap_pend_n = 1'b0;
                  state_n    = GAP;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         GAP: begin
            if (bit_end) begin
               if (bc == GAP_LAST) begin
                  bc_n    = '0;
                  state_n = IDLE;
               end else begin
                  bc_n = bc + 4'd1;
               end
            end
         end
         default: begin
            state_n    = IDLE;
            hc_n       = '0;
            hb_n       = 1'b0;
            bc_n       = '0;
            gap_pend_n = 1'b0;
         end
      endcase
   end

   always_comb begin
      bit_v  = 1'b0;
      busy_n = (state_n != IDLE);
      tx_n   = 1'b0;
      case (state_n)
         SYNC: tx_n = (bc_n == 4'd0);
         DATA: begin
            bit_v = byte_n[~bc_n[2:0]];
            tx_n  = hb_n ? ~bit_v : bit_v;
         end
         PAR: begin
            bit_v = ~^byte_n;
            tx_n  = hb_n ? ~bit_v : bit_v;
         end
         default: tx_n = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_hsi_tx_coder.sv
// Self-checking bench for hsi_tx_coder; a frame/gap reference model predicts busy, tx_en and tx.
module tb_hsi_tx_coder;

   localparam int H = 2;
   localparam int G = 3;
   localparam int FRAME = 22 * H;
   localparam int GAPC  = 2 * G * H;

   logic       clk = 1'b0;
   logic       n_rst;
   logic [7:0] d;
   logic       d_rdy;
   logic       msg_end;
   logic       busy, tx, tx_en;

   int n_checks = 0;
   int n_fail   = 0;

   int         frame_left = 0;
   int         gap_left   = 0;
   bit         pend       = 1'b0;
   logic [7:0] mbyte      = '0;

   always #5 clk = ~clk;

   hsi_tx_coder #(.CLK_PER_HALFBIT(H), .GAP_BITS(G)) dut (
      .clk(clk), .n_rst(n_rst), .d(d), .d_rdy(d_rdy), .msg_end(msg_end),
      .busy(busy), .tx(tx), .tx_en(tx_en)
   );

   function automatic logic frame_tx(input int pos);
      int   hbi;
      logic b;
      hbi = pos / H;
      if (hbi < 4) return (hbi < 2);
      if (hbi < 20) b = mbyte[7 - (hbi - 4) / 2];
      else          b = ~^mbyte;
      return (hbi % 2 == 1) ? ~b : b;
   endfunction

   function automatic logic [2:0] exp_out();
      if (frame_left > 0) return {1'b1, 1'b1, frame_tx(FRAME - frame_left)};
      if (gap_left > 0)   return 3'b110;
      return 3'b000;
   endfunction

   task automatic model_reset();
      frame_left = 0;
      gap_left   = 0;
      pend       = 1'b0;
   endtask

   // Drive one cycle of inputs, advance the model across the edge, settle past the edge.
   task automatic cycle(input logic [7:0] dv, input logic rv, input logic me);
      d = dv; d_rdy = rv; msg_end = me;
      @(posedge clk);
      if (frame_left > 0) begin
         if (me) pend = 1'b1;
         frame_left--;
         if (frame_left == 0 && pend) begin
            gap_left = GAPC;
            pend     = 1'b0;
         end
      end else if (gap_left > 0) begin
         gap_left--;
      end else if (rv) begin
         mbyte      = dv;
         frame_left = FRAME;
         pend       = me;
      end else if (me) begin
         gap_left = GAPC;
      end
      #1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0; d = '0; d_rdy = 1'b0; msg_end = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, tx_en, tx} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 000", {busy, tx_en, tx});
      end
      n_rst = 1'b1;
      cycle(8'h00, 1'b0, 1'b0);
      n_checks++;
      if ({busy, tx_en, tx} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_idle: got %b want 000", {busy, tx_en, tx});
      end
   endtask

   task automatic test_single_a5();
      logic [21:0] pat;
      int busy_cnt = 0;
      pat = 22'b11_00_10_01_10_01_01_10_01_10_10;
      cycle(8'hA5, 1'b1, 1'b0);
      for (int i = 0; i < FRAME + 10; i++) begin
         if (i > 0) cycle(8'h00, 1'b0, 1'b0);
         if (busy === 1'b1) busy_cnt++;
         n_checks++;
         if ({busy, tx_en, tx} !== exp_out()) begin
            n_fail++;
            $display("FAIL a5_model cyc %0d: got %b want %b", i, {busy, tx_en, tx}, exp_out());
         end
         if (i < FRAME) begin
            n_checks++;
            if (tx !== pat[21 - i / H]) begin
               n_fail++;
               $display("FAIL a5_pattern cyc %0d: got %b want %b", i, tx, pat[21 - i / H]);
            end
         end
      end
      n_checks++;
      if (busy_cnt != FRAME) begin
         n_fail++;
         $display("FAIL a5_busy_len: got %0d want %0d", busy_cnt, FRAME);
      end
   endtask

   task automatic test_back_to_back();
      int busy_cnt = 0;
      int sent = 1;
      cycle(8'hFF, 1'b1, 1'b0);
      for (int i = 0; i < 2 * FRAME + 10; i++) begin
         if (busy === 1'b1) busy_cnt++;
         n_checks++;
         if ({busy, tx_en, tx} !== exp_out()) begin
            n_fail++;
            $display("FAIL b2b_model cyc %0d: got %b want %b", i, {busy, tx_en, tx}, exp_out());
         end
         if (busy === 1'b0 && sent == 1) begin
            sent = 2;
            cycle(8'h00, 1'b1, 1'b0);
         end else begin
            cycle(8'h00, 1'b0, 1'b0);
         end
      end
      n_checks++;
      if (busy_cnt != 2 * FRAME) begin
         n_fail++;
         $display("FAIL b2b_busy_len: got %0d want %0d", busy_cnt, 2 * FRAME);
      end
   endtask

   task automatic test_msg_end_gap();
      int busy_cnt = 0;
      int low_en_cnt = 0;
      cycle(8'h3C, 1'b1, 1'b0);
      for (int i = 0; i < FRAME + GAPC + 10; i++) begin
         if (busy === 1'b1) busy_cnt++;
         if (i >= FRAME && tx_en === 1'b1 && tx === 1'b0) low_en_cnt++;
         n_checks++;
         if ({busy, tx_en, tx} !== exp_out()) begin
            n_fail++;
            $display("FAIL gap_model cyc %0d: got %b want %b", i, {busy, tx_en, tx}, exp_out());
         end
         cycle(8'h00, 1'b0, (i == 12));
      end
      n_checks++;
      if (busy_cnt != FRAME + GAPC || low_en_cnt != GAPC) begin
         n_fail++;
         $display("FAIL gap_len: got busy %0d gap %0d want %0d %0d",
                  busy_cnt, low_en_cnt, FRAME + GAPC, GAPC);
      end
   endtask

   task automatic test_idle_gap();
      int busy_cnt = 0;
      int tx_cnt = 0;
      cycle(8'hC3, 1'b0, 1'b1);
      for (int i = 0; i < GAPC + 5; i++) begin
         if (busy === 1'b1) busy_cnt++;
         if (tx === 1'b1) tx_cnt++;
         n_checks++;
         if ({busy, tx_en, tx} !== exp_out()) begin
            n_fail++;
            $display("FAIL idle_gap_model cyc %0d: got %b want %b", i, {busy, tx_en, tx}, exp_out());
         end
         cycle(8'h00, 1'b0, 1'b0);
      end
      n_checks++;
      if (busy_cnt != GAPC || tx_cnt != 0) begin
         n_fail++;
         $display("FAIL idle_gap_len: got busy %0d tx %0d want %0d 0", busy_cnt, tx_cnt, GAPC);
      end
      busy_cnt = 0;
      cycle(8'h96, 1'b1, 1'b1);
      for (int i = 0; i < FRAME + GAPC + 5; i++) begin
         if (busy === 1'b1) busy_cnt++;
         n_checks++;
         if ({busy, tx_en, tx} !== exp_out()) begin
            n_fail++;
            $display("FAIL both_model cyc %0d: got %b want %b", i, {busy, tx_en, tx}, exp_out());
         end
         cycle(8'h00, 1'b0, 1'b0);
      end
      n_checks++;
      if (busy_cnt != FRAME + GAPC) begin
         n_fail++;
         $display("FAIL both_len: got %0d want %0d", busy_cnt, FRAME + GAPC);
      end
   endtask

   task automatic test_ignore_busy();
      int busy_cnt = 0;
      cycle(8'h81, 1'b1, 1'b0);
      for (int i = 0; i < FRAME + 10; i++) begin
         if (busy === 1'b1) busy_cnt++;
         n_checks++;
         if ({busy, tx_en, tx} !== exp_out()) begin
            n_fail++;
            $display("FAIL ignore_model cyc %0d: got %b want %b", i, {busy, tx_en, tx}, exp_out());
         end
         cycle(8'h55, (i >= 4 && i < 30), 1'b0);
      end
      n_checks++;
      if (busy_cnt != FRAME) begin
         n_fail++;
         $display("FAIL ignore_len: got %0d want %0d", busy_cnt, FRAME);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         cycle(8'($urandom), ($urandom_range(3) == 0), ($urandom_range(15) == 0));
         n_checks++;
         if ({busy, tx_en, tx} !== exp_out()) begin
            n_fail++;
            $display("FAIL random cyc %0d: got %b want %b", i, {busy, tx_en, tx}, exp_out());
         end
      end
      for (int i = 0; i < FRAME + GAPC + 2; i++) cycle(8'h00, 1'b0, 1'b0);
      n_checks++;
      if ({busy, tx_en, tx} !== 3'b000) begin
         n_fail++;
         $display("FAIL random_drain: got %b want 000", {busy, tx_en, tx});
      end
   endtask

   task automatic test_reset_abort();
      cycle(8'hE7, 1'b1, 1'b1);
      for (int i = 0; i < 14; i++) cycle(8'h00, 1'b0, 1'b0);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_pre: got busy %b want 1", busy);
      end
      #2;
      n_rst = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({busy, tx_en, tx} !== 3'b000) begin
         n_fail++;
         $display("FAIL abort_async: got %b want 000", {busy, tx_en, tx});
      end
      @(posedge clk);
      #3;
      n_rst = 1'b1;
      for (int i = 0; i < 30; i++) begin
         cycle(8'h00, 1'b0, 1'b0);
         n_checks++;
         if ({busy, tx_en, tx} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_idle cyc %0d: got %b want 000", i, {busy, tx_en, tx});
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_a5();
      test_back_to_back();
      test_msg_end_gap();
      test_idle_gap();
      test_ignore_busy();
      test_random();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
